fib_sched: RTL
==============

# fib_sched

Round-robin scheduler that shares one Fibonacci engine (`fib`, either ARCH) among `NUM_REQ` requesters. It accepts requests, serialises them onto the engine's go/n/done handshake, and returns each result on a shared, tagged response bus. It sits between the requesting clients and a single `fib` instance, so the engine area is not replicated per client.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `INPUT_WIDTH`, 6: width of each `n` operand; matches the engine.
- `OUTPUT_WIDTH`, 32: result width; matches the engine.
- `ID_WIDTH`, `$clog2(NUM_REQ)` (minimum 1): width of `rsp_id`.
- `clk`  in  1  the single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  request level from each requester.
- `req_n`  in  NUM_REQ*INPUT_WIDTH  operand for requester i in `[i*INPUT_WIDTH +: INPUT_WIDTH]`.
- `gnt`  out  NUM_REQ  one-hot, one-cycle pulse; marks the cycle the operand is taken.
- `rsp_valid`  out  1  one-cycle pulse; response bus valid.
- `rsp_id`  out  ID_WIDTH  index of the requester this response belongs to.
- `rsp_result`  out  OUTPUT_WIDTH  engine result.
- `rsp_overflow`  out  1  engine overflow flag.
- `busy`  out  1  high in every state except IDLE.
- `fib_go`  out  1  go to the engine.
- `fib_n`  out  INPUT_WIDTH  operand to the engine.
- `fib_result`  in  OUTPUT_WIDTH  from the engine.
- `fib_overflow`  in  1  from the engine.
- `fib_done`  in  1  from the engine. It stays high after completion until the engine samples the next go. It is low by the cycle after go.

## Operation
- FSM states: IDLE, START, WAIT, RESP. All outputs are registered.
- **IDLE**
  - If any `req` bit is high, select the winner by round-robin from pointer `ptr`: the first set bit at index >= `ptr`, wrapping modulo NUM_REQ.
  - Latch the winner's operand into `fib_n` and its index into the tag register.
  - Next state is START.
- **START**
  - `fib_go`=1 and `gnt[winner]`=1 for exactly this cycle.
  - `ptr` <= (winner+1) mod NUM_REQ.
  - Next state is WAIT.
- **WAIT**
  - `fib_done` is ignored in the first WAIT cycle (stale-done guard).
  - From the second WAIT cycle on, `fib_done`=1 captures `fib_result` and `fib_overflow` and moves to RESP.
  - The state waits indefinitely; there is no timeout.
- **RESP**
  - `rsp_valid`=1 for one cycle, with `rsp_id`, `rsp_result` and `rsp_overflow` held.
  - Next state is IDLE.
- `rsp_id`, `rsp_result` and `rsp_overflow` hold their last values while `rsp_valid`=0.
- `fib_n` holds during START and WAIT.
- **Requester rules**
  - Keep `req` high and `req_n` stable until `gnt` is seen.
  - A requester deasserts `req` in the cycle after `gnt`, or keeps it high to issue a new request.
  - `req` changes by non-granted requesters are legal at any time.
- **Arbitration edge cases**
  - Only one request is ever in flight.
  - Requests that arrive during START, WAIT or RESP are evaluated in the next IDLE cycle.
  - When the requester at `ptr` and others are all high, `ptr` wins.
  - A requester that holds `req` continuously is served at most once per NUM_REQ grants while others are pending.
- **Reset**
  - `rst`=0 at any time, including mid-WAIT, forces IDLE immediately.
  - Reset values: `ptr`=0; `gnt`, `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_overflow`, `busy`, `fib_go` and `fib_n` all 0.
  - An in-flight request is dropped with no response.
  - The engine must be reset in the same event. Its `rst` is active-high, so drive it from `~rst`.

## Timing
- `req` high in cycle c (IDLE) gives `gnt` and `fib_go` high in cycle c+1 and WAIT from c+2.
- `fib_done` is first honoured in cycle c+3.
- `fib_done` first honoured in cycle d gives `rsp_valid` in cycle d+1 and IDLE in d+2.
- The next `gnt` comes no earlier than d+3.
- Minimum request-to-response latency is 4 cycles plus the engine latency.
- `busy` rises in c+1 and falls in d+2.

## Test plan
- Single request, using a `fib` engine with fib(1)=fib(2)=1: requester 2, n=10 -> `gnt`=4'b0100 for exactly 1 cycle, then `rsp_valid` with `rsp_id`=2, `rsp_result`=55, `rsp_overflow`=0.
- All four requesters held high at once, operands 5/6/7/8 -> grants in order 0,1,2,3, then repeat 0. Responses are 5, 8, 13, 21 in that order.
- Overflow, OUTPUT_WIDTH=32: n=47 -> 2971215073 with `rsp_overflow`=0. n=48 -> `rsp_overflow`=1.
- Stale done: issue back-to-back requests and check that the second `rsp_valid` never fires from the first operation's `fib_done`. `rsp_result` must change to the new value.
- Reset mid-WAIT: drop `rst` for 1 cycle during WAIT -> all outputs are 0 and `ptr` is 0. No `rsp_valid` appears. A new request completes normally.
- Requester 3 held high while requesters 0 and 1 alternate -> requester 3 is granted at least once every 4 grants.

Source files
------------

// File: rtl/fib_sched.sv
// fib_sched: round-robin scheduler that serialises NUM_REQ requesters onto one
// shared Fibonacci engine and returns each result on a tagged response bus.
module fib_sched #(
  parameter int NUM_REQ      = 4,
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 32,
  parameter int ID_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_n,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           rsp_valid,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [OUTPUT_WIDTH-1:0]        rsp_result,
  output logic                           rsp_overflow,
  output logic                           busy,
  output logic                           fib_go,
  output logic [INPUT_WIDTH-1:0]         fib_n,
  input  logic [OUTPUT_WIDTH-1:0]        fib_result,
  input  logic                           fib_overflow,
  input  logic                           fib_done
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t                  state, state_d;
  logic [ID_WIDTH-1:0]     ptr, ptr_d;
  logic [ID_WIDTH-1:0]     tag, tag_d;
  logic                    first_wait, first_wait_d;
  logic [NUM_REQ-1:0]      gnt_d;
  logic                    fib_go_d;
  logic [INPUT_WIDTH-1:0]  fib_n_d;
  logic                    rsp_valid_d;
  logic [ID_WIDTH-1:0]     rsp_id_d;
  logic [OUTPUT_WIDTH-1:0] rsp_result_d;
  logic                    rsp_overflow_d;
  logic                    busy_d;

  logic                    found;
  logic [ID_WIDTH-1:0]     cand;
  logic [ID_WIDTH-1:0]     winner;
  logic [INPUT_WIDTH-1:0]  winner_n;

  function automatic logic [ID_WIDTH-1:0] rr_index(input logic [ID_WIDTH-1:0] base,
                                                   input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_WIDTH'(sum);
  endfunction

  // Scan from ptr upwards with wrap; the first set bit wins.
  always_comb begin
    found    = 1'b0;
    cand     = '0;
    winner   = '0;
    winner_n = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_index(ptr, k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_WIDTH'(i)) winner_n = req_n[i*INPUT_WIDTH +: INPUT_WIDTH];
    end
  end

  always_comb begin
    state_d        = state;
    ptr_d          = ptr;
    tag_d          = tag;
    first_wait_d   = first_wait;
    gnt_d          = '0;
    fib_go_d       = 1'b0;
    fib_n_d        = fib_n;
    rsp_valid_d    = 1'b0;
    rsp_id_d       = rsp_id;
    rsp_result_d   = rsp_result;
    rsp_overflow_d = rsp_overflow;
    case (state)
      IDLE: begin
        if (found) begin
          tag_d    = winner;
          fib_n_d  = winner_n;
          gnt_d    = NUM_REQ'(1) << winner;
          fib_go_d = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        ptr_d        = (tag == ID_WIDTH'(NUM_REQ - 1)) ? '0 : tag + ID_WIDTH'(1);
        first_wait_d = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        // The engine may still show done from the previous job for one cycle.
        first_wait_d = 1'b0;
        if (!first_wait && fib_done) begin
          rsp_valid_d    = 1'b1;
          rsp_id_d       = tag;
          rsp_result_d   = fib_result;
          rsp_overflow_d = fib_overflow;
          state_d        = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= '0;
      tag          <= '0;
      first_wait   <= 1'b0;
      gnt          <= '0;
      fib_go       <= 1'b0;
      fib_n        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      ptr          <= ptr_d;
      tag          <= tag_d;
      first_wait   <= first_wait_d;
      gnt          <= gnt_d;
      fib_go       <= fib_go_d;
      fib_n        <= fib_n_d;
      rsp_valid    <= rsp_valid_d;
      rsp_id       <= rsp_id_d;
      rsp_result   <= rsp_result_d;
      rsp_overflow <= rsp_overflow_d;
      busy         <= busy_d;
    end
  end

endmodule
